// File: rtl/gfx_vbus_arbiter_if.sv
`default_nettype none
// ============================================================================
// gfx_vbus_arbiter_if : control-register window, scanout handshake, VRAM bus
// Revision 1.0
// ============================================================================
interface gfx_vbus_arbiter_if;
  logic        i_free_vbus_b;
  logic        i_ctrl_ce_b;
  logic        i_ctrl_ce2;
  logic        i_ctrl_w_b;
  logic [1:0]  i_ctrl_addr;
  logic [7:0]  i_ctrl_data;
  logic        o_addr_sel;
  logic [15:0] o_dma_addr;
  logic [7:0]  o_dma_data;
  logic        o_dma_data_oe_b;
  logic        o_vram_we_b;
  logic        o_busy;
  logic        o_full;
  logic        o_overflow;

  modport slave (
    input  i_free_vbus_b, i_ctrl_ce_b, i_ctrl_ce2, i_ctrl_w_b, i_ctrl_addr, i_ctrl_data,
    output o_addr_sel, o_dma_addr, o_dma_data, o_dma_data_oe_b, o_vram_we_b,
           o_busy, o_full, o_overflow
  );

  modport master (
    output i_free_vbus_b, i_ctrl_ce_b, i_ctrl_ce2, i_ctrl_w_b, i_ctrl_addr, i_ctrl_data,
    input  o_addr_sel, o_dma_addr, o_dma_data, o_dma_data_oe_b, o_vram_we_b,
           o_busy, o_full, o_overflow
  );
endinterface
`default_nettype wire

// File: rtl/gfx_vbus_arbiter.sv
`default_nettype none
// ============================================================================
// gfx_vbus_arbiter : buffers CPU VRAM writes and drains them in scanout gaps
// Revision 1.0
// ============================================================================
module gfx_vbus_arbiter #(
  parameter int FifoDepthLog2 = 2
) (
  input  wire logic i_clk,
  input  wire logic i_rst,
  gfx_vbus_arbiter_if.slave bus
);
  localparam int                 c_DEPTH_I = 1 << FifoDepthLog2;
  localparam logic [FifoDepthLog2:0] c_DEPTH = c_DEPTH_I[FifoDepthLog2:0];

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SETUP = 2'd1,
    S_WRITE = 2'd2,
    S_HOLD  = 2'd3
  } t_state;

  t_state r_state, w_state_nxt;

  logic        r_w_b_d;
  logic [15:0] r_addr;
  logic        r_autoinc;
  logic        r_overflow;

  logic [23:0]              r_mem [c_DEPTH_I];
  logic [FifoDepthLog2-1:0] r_wr_ptr, r_rd_ptr;
  logic [FifoDepthLog2:0]   r_count;

  logic        r_addr_sel, r_oe_b, r_we_b;
  logic [15:0] r_dma_addr;
  logic [7:0]  r_dma_data;

  logic        w_wr, w_push_req, w_push, w_pop, w_drop, w_full, w_empty;
  logic [23:0] w_head;

  // A write is the first selected cycle after the strobe goes low.
  assign w_wr       = ~bus.i_ctrl_ce_b & bus.i_ctrl_ce2 & ~bus.i_ctrl_w_b & r_w_b_d;
  assign w_push_req = w_wr && (bus.i_ctrl_addr == 2'd2);
  assign w_full     = (r_count == c_DEPTH);
  assign w_empty    = (r_count == '0);
  assign w_pop      = (r_state == S_HOLD);
  assign w_push     = w_push_req && (!w_full || w_pop);
  assign w_drop     = w_push_req && w_full && !w_pop;
  assign w_head     = r_mem[r_rd_ptr];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_w_b_d    <= 1'b1;
      r_addr     <= 16'h0000;
      r_autoinc  <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_w_b_d <= bus.i_ctrl_w_b;
      if (w_wr) begin
        case (bus.i_ctrl_addr)
          2'd0: r_addr[7:0]  <= bus.i_ctrl_data;
          2'd1: r_addr[15:8] <= bus.i_ctrl_data;
          2'd2: if (w_push && r_autoinc) r_addr <= r_addr + 16'd1;
          default: begin
            r_autoinc <= bus.i_ctrl_data[0];
            if (bus.i_ctrl_data[7]) r_overflow <= 1'b0;
          end
        endcase
      end
      if (w_drop) r_overflow <= 1'b1;
    end
  end

  // Storage needs no reset; the pointers alone define the contents.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {r_addr, bus.i_ctrl_data};
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (!w_empty && !bus.i_free_vbus_b) w_state_nxt = S_SETUP;
      S_SETUP: w_state_nxt = bus.i_free_vbus_b ? S_IDLE : S_WRITE;
      S_WRITE: w_state_nxt = S_HOLD;
      S_HOLD:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Bus controls are registered from the next state so they align with it.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_addr_sel <= 1'b0;
      r_oe_b     <= 1'b1;
      r_we_b     <= 1'b1;
      r_dma_addr <= 16'h0000;
      r_dma_data <= 8'h00;
    end else begin
      r_addr_sel <= (w_state_nxt != S_IDLE);
      r_oe_b     <= (w_state_nxt == S_IDLE);
      r_we_b     <= (w_state_nxt != S_WRITE);
      if (r_state == S_IDLE && w_state_nxt == S_SETUP) begin
        r_dma_addr <= w_head[23:8];
        r_dma_data <= w_head[7:0];
      end
    end
  end

  assign bus.o_addr_sel      = r_addr_sel;
  assign bus.o_dma_addr      = r_dma_addr;
  assign bus.o_dma_data      = r_dma_data;
  assign bus.o_dma_data_oe_b = r_oe_b;
  assign bus.o_vram_we_b     = r_we_b;
  assign bus.o_busy          = !w_empty || (r_state != S_IDLE);
  assign bus.o_full          = w_full;
  assign bus.o_overflow      = r_overflow;
endmodule
`default_nettype wire

// File: tb/tb_gfx_vbus_arbiter.sv
`default_nettype none
// ============================================================================
// tb_gfx_vbus_arbiter : directed stimulus with a write scoreboard
// Revision 1.0
// ============================================================================
module tb_gfx_vbus_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  gfx_vbus_arbiter_if vif();

  gfx_vbus_arbiter #(.FifoDepthLog2(2)) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (vif.slave)
  );

  typedef struct {
    logic [15:0] a;
    logic [7:0]  d;
  } t_exp;

  t_exp        q[$];
  logic [7:0]  ram [logic [15:0]];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_writes = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every cycle with the write strobe low is one VRAM write.
  always @(negedge clk) begin
    if (vif.o_vram_we_b === 1'b0) begin
      t_exp e;
      n_writes++;
      ram[vif.o_dma_addr] = vif.o_dma_data;
      if (q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: got addr %0h data %0h expected none",
                 vif.o_dma_addr, vif.o_dma_data);
      end else begin
        e = q.pop_front();
        check("wr_addr", {16'h0, vif.o_dma_addr}, {16'h0, e.a});
        check("wr_data", {24'h0, vif.o_dma_data}, {24'h0, e.d});
        check("wr_owned", {30'h0, vif.o_addr_sel, vif.o_dma_data_oe_b}, 32'h2);
      end
    end
  end

  task automatic reg_wr(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    vif.i_ctrl_ce_b = 1'b0;
    vif.i_ctrl_ce2  = 1'b1;
    vif.i_ctrl_addr = a;
    vif.i_ctrl_data = d;
    vif.i_ctrl_w_b  = 1'b0;
    repeat (2) @(negedge clk);
    vif.i_ctrl_w_b  = 1'b1;
    @(negedge clk);
    vif.i_ctrl_ce_b = 1'b1;
    vif.i_ctrl_ce2  = 1'b0;
  endtask

  task automatic push(input logic [15:0] a, input logic [7:0] d);
    q.push_back('{a, d});
    reg_wr(2'd2, d);
  endtask

  task automatic wait_idle(input string name);
    logic ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (vif.o_busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    check(name, {31'h0, ok}, 32'h1);
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    logic found;
    vif.i_free_vbus_b = 1'b0;
    vif.i_ctrl_ce_b   = 1'b1;
    vif.i_ctrl_ce2    = 1'b0;
    vif.i_ctrl_w_b    = 1'b1;
    vif.i_ctrl_addr   = 2'd0;
    vif.i_ctrl_data   = 8'h00;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_addr_sel", {31'h0, vif.o_addr_sel}, 32'h0);
    check("rst_dma_addr", {16'h0, vif.o_dma_addr}, 32'h0);
    check("rst_dma_data", {24'h0, vif.o_dma_data}, 32'h0);
    check("rst_oe_b",     {31'h0, vif.o_dma_data_oe_b}, 32'h1);
    check("rst_we_b",     {31'h0, vif.o_vram_we_b}, 32'h1);
    check("rst_flags",    {29'h0, vif.o_busy, vif.o_full, vif.o_overflow}, 32'h0);
    rst = 1'b0;

    // Single write with cycle-exact latency
    reg_wr(2'd0, 8'h34);
    reg_wr(2'd1, 8'h12);
    q.push_back('{16'h1234, 8'hAB});
    @(negedge clk);
    vif.i_ctrl_ce_b = 1'b0;
    vif.i_ctrl_ce2  = 1'b1;
    vif.i_ctrl_addr = 2'd2;
    vif.i_ctrl_data = 8'hAB;
    vif.i_ctrl_w_b  = 1'b0;
    @(negedge clk);
    check("lat_push_busy", {30'h0, vif.o_busy, vif.o_vram_we_b}, 32'h3);
    @(negedge clk);
    check("lat_setup_ctl", {29'h0, vif.o_addr_sel, vif.o_dma_data_oe_b, vif.o_vram_we_b}, 32'h5);
    check("lat_setup_addr", {16'h0, vif.o_dma_addr}, 32'h1234);
    @(negedge clk);
    check("lat_write_we", {31'h0, vif.o_vram_we_b}, 32'h0);
    @(negedge clk);
    check("lat_hold_ctl", {29'h0, vif.o_addr_sel, vif.o_dma_data_oe_b, vif.o_vram_we_b}, 32'h5);
    check("lat_hold_data", {24'h0, vif.o_dma_data}, 32'hAB);
    vif.i_ctrl_w_b = 1'b1;
    @(negedge clk);
    vif.i_ctrl_ce_b = 1'b1;
    vif.i_ctrl_ce2  = 1'b0;
    wait_idle("idle_single");
    check("single_count", n_writes, 1);
    found = ram.exists(16'h1234);
    check("ram_1234_exists", {31'h0, found}, 32'h1);
    if (found) check("ram_1234", {24'h0, ram[16'h1234]}, 32'hAB);

    // Auto-increment across the 0xFFFF wrap
    reg_wr(2'd3, 8'h01);
    reg_wr(2'd0, 8'hFE);
    reg_wr(2'd1, 8'hFF);
    push(16'hFFFE, 8'hC0);
    push(16'hFFFF, 8'hC1);
    push(16'h0000, 8'hC2);
    wait_idle("idle_autoinc");
    check("autoinc_count", n_writes, 4);

    // Fill, overflow, drain while the bus is blocked
    vif.i_free_vbus_b = 1'b1;
    reg_wr(2'd0, 8'h00);
    reg_wr(2'd1, 8'h20);
    for (int i = 0; i < 4; i++) push(16'h2000 + 16'(i), 8'h10 + 8'(i));
    check("full_after4", {30'h0, vif.o_full, vif.o_overflow}, 32'h2);
    reg_wr(2'd2, 8'h14);
    check("ovf_after5", {30'h0, vif.o_full, vif.o_overflow}, 32'h3);
    check("blocked_no_write", n_writes, 4);
    check("blocked_addr_sel", {31'h0, vif.o_addr_sel}, 32'h0);
    vif.i_free_vbus_b = 1'b0;
    wait_idle("idle_drain");
    check("drain_count", n_writes, 8);
    check("drain_flags", {30'h0, vif.o_full, vif.o_overflow}, 32'h1);
    push(16'h2004, 8'h55);
    wait_idle("idle_after_drop");
    reg_wr(2'd3, 8'h80);
    check("ovf_cleared", {31'h0, vif.o_overflow}, 32'h0);

    // Abort in SETUP keeps the entry
    vif.i_free_vbus_b = 1'b1;
    reg_wr(2'd0, 8'h00);
    reg_wr(2'd1, 8'h30);
    push(16'h3000, 8'h77);
    base = n_writes;
    @(negedge clk);
    vif.i_free_vbus_b = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (vif.o_addr_sel === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    vif.i_free_vbus_b = 1'b1;
    check("abort_reached_setup", {31'h0, found}, 32'h1);
    repeat (6) @(negedge clk);
    check("abort_no_write", n_writes, base);
    check("abort_state", {30'h0, vif.o_addr_sel, vif.o_busy}, 32'h1);
    vif.i_free_vbus_b = 1'b0;
    wait_idle("idle_abort");
    check("abort_retry_count", n_writes, base + 1);

    // Reset during WRITE flushes the FIFO
    vif.i_free_vbus_b = 1'b1;
    reg_wr(2'd0, 8'h00);
    reg_wr(2'd1, 8'h31);
    push(16'h3100, 8'h81);
    reg_wr(2'd0, 8'h01);
    push(16'h3101, 8'h82);
    vif.i_free_vbus_b = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (vif.o_vram_we_b === 1'b0) begin
        found = 1'b1;
        break;
      end
    end
    rst = 1'b1;
    check("rst_reached_write", {31'h0, found}, 32'h1);
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    check("midrst_ctl", {29'h0, vif.o_addr_sel, vif.o_dma_data_oe_b, vif.o_vram_we_b}, 32'h3);
    check("midrst_flags", {29'h0, vif.o_busy, vif.o_full, vif.o_overflow}, 32'h0);
    base = n_writes;
    repeat (20) @(negedge clk);
    check("midrst_no_write", n_writes, base);

    // Address register is back at zero after reset
    push(16'h0000, 8'h99);
    wait_idle("idle_post_rst");
    check("post_rst_count", n_writes, base + 1);

    check("scoreboard_empty", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
